dma_rqst_arbiter: RTL

//  Shares one DMA controller port between N_DEV DMA peripherals using round-robin arbitration.

---
 rtl/dma_rqst_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/dma_rqst_arbiter.sv
// Round-robin arbiter sharing one DMA controller port among N_DEV peripherals.
// The grant is held for a whole transfer and released through a one-cycle gap state.

module dma_rqst_lane (
    input  logic gnt_i,
    input  logic act_i,
    input  logic done_i,
    input  logic ack_i,
    input  logic end_i,
    output logic dma_ack_o,
    output logic dma_end_o
);
    assign dma_ack_o = gnt_i & act_i & ack_i;
    assign dma_end_o = gnt_i & ((act_i & end_i) | done_i);
endmodule

module dma_rqst_arbiter #(
    parameter int N_DEV = 4,
    parameter int IDX_W = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_DEV-1:0]     dev_rqst,
    input  logic [N_DEV-1:0]     dev_rd_wr,
    input  logic [16*N_DEV-1:0]  dev_start_address,
    input  logic [16*N_DEV-1:0]  dev_num_words,
    input  logic [N_DEV-1:0]     dev_ack,
    input  logic [16*N_DEV-1:0]  dev_out,
    output logic [N_DEV-1:0]     dev_dma_ack,
    output logic [N_DEV-1:0]     dev_dma_end_flag,
    output logic [15:0]          dev_dma_din,
    output logic                 ctl_rqst,
    output logic                 ctl_rd_wr,
    output logic [15:0]          ctl_start_address,
    output logic [15:0]          ctl_num_words,
    output logic                 ctl_dev_ack,
    output logic [15:0]          ctl_dev_out,
    input  logic                 ctl_ack,
    input  logic                 ctl_end_flag,
    input  logic [15:0]          ctl_dev_in,
    output logic [N_DEV-1:0]     gnt,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, ACTIVE, DONE, RELEASE} state_e;

    state_e             state_q, state_d;
    logic [N_DEV-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic               found;
    logic [IDX_W-1:0]   pick_idx;
    logic               sel_v, act, done;

    logic [15:0] addr_a  [N_DEV];
    logic [15:0] words_a [N_DEV];
    logic [15:0] out_a   [N_DEV];

    assign act  = (state_q == ACTIVE);
    assign done = (state_q == DONE);

    genvar i;
    generate
        for (i = 0; i < N_DEV; i++) begin : g_lane
            assign addr_a[i]  = dev_start_address[16*i +: 16];
            assign words_a[i] = dev_num_words[16*i +: 16];
            assign out_a[i]   = dev_out[16*i +: 16];

            dma_rqst_lane u_lane (
                .gnt_i     (gnt_q[i]),
                .act_i     (act),
                .done_i    (done),
                .ack_i     (ctl_ack),
                .end_i     (ctl_end_flag),
                .dma_ack_o (dev_dma_ack[i]),
                .dma_end_o (dev_dma_end_flag[i])
            );
        end
    endgenerate

    // Scan last+1, last+2, ... so the most recent winner is checked last.
    always_comb begin : p_pick
        int j;
        found    = 1'b0;
        pick_idx = '0;
        for (int k = 1; k <= N_DEV; k++) begin
            j = int'(last_q) + k;
            if (j >= N_DEV) j = j - N_DEV;
            if (!found && dev_rqst[IDX_W'(j)]) begin
                found    = 1'b1;
                pick_idx = IDX_W'(j);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d         = ACTIVE;
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    idx_d           = pick_idx;
                    last_d          = pick_idx;
                end
            end
            ACTIVE: begin
                if (ctl_end_flag) begin
                    state_d = DONE;
                end else if (!dev_rqst[idx_q]) begin
                    state_d = RELEASE;
                    gnt_d   = '0;
                end
            end
            DONE: begin
                if (!dev_rqst[idx_q]) begin
                    state_d = RELEASE;
                    gnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            last_q  <= IDX_W'(N_DEV-1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

    // The mux is keyed off the registered grant so an empty grant forces zeros.
    assign sel_v             = |gnt_q;
    assign ctl_rqst          = act & dev_rqst[idx_q];
    assign ctl_rd_wr         = sel_v & dev_rd_wr[idx_q];
    assign ctl_dev_ack       = sel_v & dev_ack[idx_q];
    assign ctl_start_address = sel_v ? addr_a[idx_q]  : 16'h0;
    assign ctl_num_words     = sel_v ? words_a[idx_q] : 16'h0;
    assign ctl_dev_out       = sel_v ? out_a[idx_q]   : 16'h0;
    assign dev_dma_din       = ctl_dev_in;
    assign gnt               = gnt_q;
    assign busy              = (state_q != IDLE);
endmodule
